div_ratio_ctrl: RTL and testbench
=================================

# div_ratio_ctrl

Programmable clock-divide controller that sequences a single-clock divider: it runs a period counter against an active divide ratio and emits a one-cycle `tick` per period plus a near-50%-duty `div_out` level. It accepts ratio changes over a valid/ready handshake and applies them only at a period boundary, so output periods are never truncated or stretched. Start/stop via `en` is likewise graceful at period boundaries. It sits in front of the fixed dividers as the block that configures and gates divided timing for downstream logic.

## Interface
- `CNT_W`, 4, width of divide ratio and period counter
- `DEF_RATIO`, 3, ratio loaded at reset; must be 1..2^CNT_W-1
- `clk_in`  in  1  sole clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  run request; level-sensitive
- `cfg_valid`  in  1  new ratio offered
- `cfg_ratio`  in  CNT_W  offered ratio N
- `cfg_ready`  out  1  controller can accept a ratio this cycle
- `cfg_err`  out  1  one-cycle pulse: accepted ratio was 0 and was discarded
- `tick`  out  1  one-cycle pulse on last cycle of each period
- `div_out`  out  1  divided level
- `busy`  out  1  state is not IDLE
- `ratio_cur`  out  CNT_W  currently active ratio

## Operation
- States: IDLE, RUN, PEND (run with a ratio change pending).
- Reset (async assert): state IDLE, count 0, ratio_cur = DEF_RATIO, shadow 0, tick/div_out/cfg_err/busy 0, cfg_ready 1.
- Handshake: transfer when `cfg_valid && cfg_ready` at posedge. cfg_ready = 1 in IDLE and RUN, 0 in PEND. Requester holds valid/data until transfer.
- Ratio 0 is transferred but discarded; cfg_err pulses next cycle; state unchanged.
- IDLE: transfer with N≠0 loads ratio_cur next cycle. `en`=1 → RUN, count 0. Transfer and en in same cycle: both take effect; run starts with new ratio.
- RUN: count increments each cycle; at count == ratio_cur-1 (wrap) count → 0. Transfer with N≠0 → shadow = N, state PEND.
- PEND: at wrap, ratio_cur ← shadow, count ← 0, state → RUN.
- Stop: `en` sampled low at a wrap cycle → IDLE after that wrap (pending shadow applied at that same wrap). `en` low mid-period has no effect until wrap; re-raising before wrap continues seamlessly.
- `tick` = 1 for exactly the wrap cycle of every period while RUN/PEND, including the final period before IDLE.
- `div_out` = 1 while count < ceil(ratio_cur/2), else 0; N=1 → div_out constant 1, tick every cycle. 0 in IDLE.
- Counter width CNT_W, unsigned; no overflow possible since count ≤ ratio_cur-1.

## Timing
- All outputs are functions of registers only; no input→output combinational path.
- `en` high at edge k → busy 1 and count 0 from k+1; first tick at cycle k+N (N cycles after entry).
- Period length exactly ratio_cur cycles; a new ratio affects the period beginning the cycle after the wrap.
- Transfer at edge k → cfg_err (if N=0) high cycle k+1 only.
- Reset mid-period: outputs return to reset values immediately (async); pending shadow lost.

## Structure
- Package `div_ctrl_pkg`: state typedef (IDLE, RUN, PEND), DEF_RATIO default constant.
- Sub-module `div_period_counter`: CNT_W counter with clear, run enable, ratio input, outputs count and wrap. Controller FSM, shadow register, and output decode stay in top.

## Test plan
- Reset then en=1, N=3 → tick every 3rd cycle starting 3 cycles after entry; div_out pattern 1,1,0 repeating; ratio_cur 3.
- RUN at N=3, offer 5 mid-period → cfg_ready drops, current period finishes at 3 cycles, next periods 5 cycles, div_out 1,1,1,0,0.
- Offer 0 → transfer completes, cfg_err one-cycle pulse, ratio_cur unchanged, state unchanged.
- en low at count 0 with N=4 → 4 more cycles, final tick, then busy 0, div_out 0; en low then high before wrap → no gap in ticks.
- N=1 → tick every cycle, div_out constant 1; change to 2 while pending and en dropped same period → IDLE with ratio_cur 2.
- Assert reset in PEND → immediate IDLE, ratio_cur DEF_RATIO, cfg_ready 1, shadow discarded.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the programmable clock-divide controller.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 4;
   localparam int DEF_RATIO = 3;

endpackage

// File: rtl/div_period_counter.sv
// Period counter: counts 0..ratio-1 while running and flags the last cycle.
module div_period_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             clr,
   input  logic             run,
   input  logic [CNT_W-1:0] ratio,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // wrap is a pure decode of the count; the caller qualifies it with its run state.
   assign wrap  = (count_q == (ratio - CNT_W'(1)));
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (run) begin
         count_d = wrap ? '0 : count_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Clock-divide controller: FSM, ratio shadow register and tick/div_out decode
// around a period counter; ratio changes and stops take effect only at a wrap.
module div_ratio_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DEF_RATIO = div_ctrl_pkg::DEF_RATIO
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_ratio,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             tick,
   output logic             div_out,
   output logic             busy,
   output logic [CNT_W-1:0] ratio_cur
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ratio_q, ratio_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cnt_clr;
   logic             cnt_run;
   logic [CNT_W-1:0] count;
   logic             wrap;
   logic             transfer;
   logic             load_ok;
   logic [CNT_W:0]   half;

   div_period_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_in (clk_in),
      .reset  (reset),
      .clr    (cnt_clr),
      .run    (cnt_run),
      .ratio  (ratio_q),
      .count  (count),
      .wrap   (wrap)
   );

   assign cnt_run  = (state_q != IDLE);
   assign transfer = cfg_valid && cfg_ready;
   assign load_ok  = transfer && (cfg_ratio != '0);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ratio_d   = ratio_q;
      shadow_d  = shadow_q;
      cfg_err_d = transfer && (cfg_ratio == '0);
      cnt_clr   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (load_ok) ratio_d = cfg_ratio;
            if (en)      state_d = RUN;
         end
         RUN: begin
            // A ratio arriving on the final wrap is the boundary itself, so it loads directly.
            if (wrap && !en) begin
               state_d = IDLE;
               if (load_ok) ratio_d = cfg_ratio;
            end else if (load_ok) begin
               shadow_d = cfg_ratio;
               state_d  = PEND;
            end
         end
         PEND: begin
            if (wrap) begin
               ratio_d = shadow_q;
               state_d = en ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the shadow register is reset too, so a pending ratio never survives reset.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ratio_q   <= CNT_W'(DEF_RATIO);
         shadow_q  <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ratio_q   <= ratio_d;
         shadow_q  <= shadow_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // High phase lasts ceil(ratio/2) cycles; widened so ratio+1 cannot overflow.
   assign half = ({1'b0, ratio_q} + (CNT_W+1)'(1)) >> 1;

   assign busy      = (state_q != IDLE);
   assign cfg_ready = (state_q != PEND);
   assign cfg_err   = cfg_err_q;
   assign tick      = busy && wrap;
   assign div_out   = busy && ({1'b0, count} < half);
   assign ratio_cur = ratio_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed self-checking bench for div_ratio_ctrl with hand-computed expectations.
module tb_div_ratio_ctrl;

   localparam int CNT_W = 4;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_ratio;
   logic             cfg_ready;
   logic             cfg_err;
   logic             tick;
   logic             div_out;
   logic             busy;
   logic [CNT_W-1:0] ratio_cur;

   int total = 0;
   int bad   = 0;

   div_ratio_ctrl #(.CNT_W(CNT_W), .DEF_RATIO(3)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ratio (cfg_ratio),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .div_out   (div_out),
      .busy      (busy),
      .ratio_cur (ratio_cur)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic t, input logic d, input logic b,
                          input logic rdy, input logic [CNT_W-1:0] r);
      check({tag, ".tick"},  32'(tick),      32'(t));
      check({tag, ".div"},   32'(div_out),   32'(d));
      check({tag, ".busy"},  32'(busy),      32'(b));
      check({tag, ".ready"}, 32'(cfg_ready), 32'(rdy));
      check({tag, ".ratio"}, 32'(ratio_cur), 32'(r));
   endtask

   initial begin
      logic [5:0] t3_tick;
      logic [5:0] t3_div;
      logic [4:0] t5_tick;
      logic [4:0] t5_div;
      t3_tick = 6'b100100;  // bit i = cycle i after entry
      t3_div  = 6'b011011;
      t5_tick = 5'b10000;
      t5_div  = 5'b00111;

      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
      #12;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      check("reset.err", 32'(cfg_err), 32'd0);
      reset = 1'b0;

      // N=3 run: ticks every third cycle, div 1,1,0
      en = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk_out($sformatf("n3.c%0d", i), t3_tick[i], t3_div[i], 1'b1, 1'b1, 4'd3);
         if (i < 5) cyc();
      end
      cyc();  // count 0

      // Offer 5 at count 0: current period finishes at 3 cycles
      cfg_valid = 1'b1; cfg_ratio = 4'd5;
      cyc();
      cfg_valid = 1'b0;
      chk_out("pend.c1", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
      cyc();
      chk_out("pend.c2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("n5.c%0d", i), t5_tick[i], t5_div[i], 1'b1, 1'b1, 4'd5);
         cyc();
      end

      // Ratio 0 offered at count 0: err pulse only
      cfg_valid = 1'b1; cfg_ratio = 4'd0;
      cyc();
      cfg_valid = 1'b0;
      check("zero.err1", 32'(cfg_err), 32'd1);
      chk_out("zero.c1", 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
      cyc();
      check("zero.err2", 32'(cfg_err), 32'd0);
      cyc();
      cyc();
      chk_out("zero.c4", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
      cyc();

      // Switch to N=4
      cfg_valid = 1'b1; cfg_ratio = 4'd4;
      cyc();
      cfg_valid = 1'b0;
      repeat (4) cyc();
      chk_out("n4.c0", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);

      // en low at count 0: full period, final tick, then idle
      en = 1'b0;
      cyc();
      chk_out("stop.c1", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
      cyc();
      chk_out("stop.c2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
      cyc();
      chk_out("stop.c3", 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
      cyc();
      chk_out("stop.idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);

      // en dropped then re-raised before wrap: no gap
      en = 1'b1;
      cyc();
      en = 1'b0;
      cyc();
      cyc();
      en = 1'b1;
      cyc();
      chk_out("blip.c3", 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
      cyc();
      chk_out("blip.next0", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);

      // Switch to N=1 at count 0
      cfg_valid = 1'b1; cfg_ratio = 4'd1;
      cyc();
      cfg_valid = 1'b0;
      cyc();
      cyc();
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk_out($sformatf("n1.c%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
         cyc();
      end

      // Offer 2 under N=1, then drop en in the pending period
      cfg_valid = 1'b1; cfg_ratio = 4'd2;
      cyc();
      cfg_valid = 1'b0;
      en = 1'b0;
      chk_out("n1.pend", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
      cyc();
      chk_out("n1.idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);

      // Reset asserted while PEND
      en = 1'b1;
      cyc();
      cfg_valid = 1'b1; cfg_ratio = 4'd7;
      cyc();
      cfg_valid = 1'b0;
      chk_out("rst.pend", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_out("rst.async", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      en = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      chk_out("rst.after", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      en = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk_out($sformatf("rst.n3.c%0d", i), t3_tick[i], t3_div[i], 1'b1, 1'b1, 4'd3);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
